// File: rtl/vernam_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module   : vernam_decrypt_if
// Function : KCPSM3 write bus, key input and plaintext stream of vernam_decrypt.
// Revision : 1.0
// ============================================================================
interface vernam_decrypt_if;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic [7:0]  key_data;
    logic        key_strobe;
    logic [7:0]  plain_data;
    logic        plain_valid;
    logic        plain_ready;
    logic        overflow;
    logic [15:0] byte_count;

    modport master (
        output port_id, out_port, write_strobe, key_data, key_strobe, plain_ready,
        input  plain_data, plain_valid, overflow, byte_count
    );

    modport slave (
        input  port_id, out_port, write_strobe, key_data, key_strobe, plain_ready,
        output plain_data, plain_valid, overflow, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/vernam_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : vernam_decrypt
// Function : Pairs buffered ciphertext and key bytes and streams their XOR.
//            Define VERNAM_DEC_LFSR_EN to replace the key FIFO with an LFSR.
// Revision : 1.0
// ============================================================================
module vernam_decrypt #(
    parameter int         DEPTH       = 4,
    parameter logic [7:0] CIPHER_PORT = 8'h04,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  wire             clk,
    input  wire             reset_n,
    vernam_decrypt_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_one   = CW'(1);

    logic [7:0]    r_plain_data;
    logic          r_plain_valid;
    logic          r_overflow;
    logic [15:0]   r_byte_count;

    logic [7:0]    r_c_mem [DEPTH];
    logic [CW-1:0] r_c_wr;
    logic [CW-1:0] r_c_rd;
    logic [CW-1:0] r_c_count;

    logic          w_c_push_req;
    logic          w_c_push;
    logic          w_c_drop;
    logic          w_c_empty;
    logic [7:0]    w_c_head;
    logic          w_k_empty;
    logic [7:0]    w_k_head;
    logic          w_k_drop;
    logic          w_pop;

    // Pairing looks only at registered counts, so a push into an empty FIFO
    // becomes poppable one cycle later.
    assign w_pop = !w_c_empty && !w_k_empty && (!r_plain_valid || bus.plain_ready);

    assign w_c_push_req = bus.write_strobe && (bus.port_id == CIPHER_PORT);
    assign w_c_empty    = (r_c_count == '0);
    assign w_c_push     = w_c_push_req && ((r_c_count != c_depth) || w_pop);
    assign w_c_drop     = w_c_push_req && !w_c_push;
    assign w_c_head     = r_c_mem[r_c_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_c_wr    <= '0;
            r_c_rd    <= '0;
            r_c_count <= '0;
        end else begin
            if (w_c_push) r_c_wr <= r_c_wr + c_one;
            if (w_pop)    r_c_rd <= r_c_rd + c_one;
            if (w_c_push && !w_pop)      r_c_count <= r_c_count + c_one;
            else if (!w_c_push && w_pop) r_c_count <= r_c_count - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_c_push) r_c_mem[r_c_wr[AW-1:0]] <= bus.out_port;
    end

`ifdef VERNAM_DEC_LFSR_EN
    localparam logic [7:0] c_lfsr_seed = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0] r_lfsr;
    logic       w_key_unused;

    assign w_key_unused = ^{bus.key_data, bus.key_strobe};

    // Galois form: shift right, fold in the tap mask when a one drops out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lfsr <= c_lfsr_seed;
        end else if (w_pop) begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign w_k_empty = 1'b0;
    assign w_k_head  = r_lfsr;
    assign w_k_drop  = 1'b0;
`else
    localparam logic [7:0] c_seed_unused = LFSR_SEED;

    logic [7:0]    r_k_mem [DEPTH];
    logic [CW-1:0] r_k_wr;
    logic [CW-1:0] r_k_rd;
    logic [CW-1:0] r_k_count;
    logic          w_k_push;

    assign w_k_empty = (r_k_count == '0);
    assign w_k_push  = bus.key_strobe && ((r_k_count != c_depth) || w_pop);
    assign w_k_drop  = bus.key_strobe && !w_k_push;
    assign w_k_head  = r_k_mem[r_k_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_k_wr    <= '0;
            r_k_rd    <= '0;
            r_k_count <= '0;
        end else begin
            if (w_k_push) r_k_wr <= r_k_wr + c_one;
            if (w_pop)    r_k_rd <= r_k_rd + c_one;
            if (w_k_push && !w_pop)      r_k_count <= r_k_count + c_one;
            else if (!w_k_push && w_pop) r_k_count <= r_k_count - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_k_push) r_k_mem[r_k_wr[AW-1:0]] <= bus.key_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_plain_data  <= 8'h00;
            r_plain_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_byte_count  <= 16'h0000;
        end else begin
            if (w_pop) begin
                r_plain_data  <= w_c_head ^ w_k_head;
                r_plain_valid <= 1'b1;
            end else if (bus.plain_ready) begin
                r_plain_valid <= 1'b0;
            end
            if (r_plain_valid && bus.plain_ready) r_byte_count <= r_byte_count + 16'd1;
            if (w_c_drop || w_k_drop)             r_overflow   <= 1'b1;
        end
    end

    assign bus.plain_data  = r_plain_data;
    assign bus.plain_valid = r_plain_valid;
    assign bus.overflow    = r_overflow;
    assign bus.byte_count  = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_vernam_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_vernam_decrypt
// Function : Self-checking bench for vernam_decrypt (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_vernam_decrypt;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    vernam_decrypt_if bus();

    vernam_decrypt #(
        .DEPTH       (4),
        .CIPHER_PORT (8'h04),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic [7:0] cipher;
        logic [7:0] plain;
    } vec_t;

    vec_t       vecs [8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    logic [3:0] pat;

    // Every accepted output byte is checked against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && bus.plain_valid && bus.plain_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %02h, none expected", bus.plain_data);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.plain_data !== mon_exp) begin
                    errors++;
                    $display("FAIL stream_data: got %02h expected %02h", bus.plain_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_key(input logic [7:0] k);
        bus.key_data   = k;
        bus.key_strobe = 1'b1;
        tick();
        bus.key_strobe = 1'b0;
    endtask

    task automatic push_cipher(input logic [7:0] p, input logic [7:0] c);
        bus.port_id      = p;
        bus.out_port     = c;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
    endtask

    task automatic push_pair(input logic [7:0] k, input logic [7:0] c);
        bus.key_data     = k;
        bus.key_strobe   = 1'b1;
        bus.port_id      = 8'h04;
        bus.out_port     = c;
        bus.write_strobe = 1'b1;
        tick();
        bus.key_strobe   = 1'b0;
        bus.write_strobe = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || bus.plain_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || bus.plain_valid) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d bytes outstanding, valid=%0b expected 0 and 0",
                     name, sb.size(), bus.plain_valid);
        end
    endtask

    task automatic do_reset();
        bus.write_strobe = 1'b0;
        bus.key_strobe   = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.port_id      = 8'h00;
        bus.out_port     = 8'h00;
        bus.write_strobe = 1'b0;
        bus.key_data     = 8'h00;
        bus.key_strobe   = 1'b0;
        bus.plain_ready  = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 8'h66};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00};
        vecs[4] = '{8'h12, 8'h34, 8'h26};
        vecs[5] = '{8'hF0, 8'h0F, 8'hFF};
        vecs[6] = '{8'h81, 8'h18, 8'h99};
        vecs[7] = '{8'hC3, 8'h5B, 8'h98};

        do_reset();
        check("reset_valid", 32'(bus.plain_valid), 32'h0);
        check("reset_data", 32'(bus.plain_data), 32'h00);
        check("reset_overflow", 32'(bus.overflow), 32'h0);
        check("reset_count", 32'(bus.byte_count), 32'h0);

`ifdef VERNAM_DEC_LFSR_EN
        bus.plain_ready = 1'b1;
        sb.push_back(8'hA5);
        sb.push_back(8'hEA);
        bus.key_data   = 8'h77;
        bus.key_strobe = 1'b1;
        push_cipher(8'h04, 8'h00);
        bus.key_strobe = 1'b1;
        push_cipher(8'h04, 8'h00);
        bus.key_strobe = 1'b1;
        repeat (8) tick();
        bus.key_strobe = 1'b0;
        wait_drain("lfsr_drain", 20);
        check("lfsr_last_data", 32'(bus.plain_data), 32'hEA);
        check("lfsr_count", 32'(bus.byte_count), 32'd2);
        check("lfsr_no_overflow", 32'(bus.overflow), 32'h0);
`else
        // Basic decrypt with first-byte latency.
        bus.plain_ready = 1'b1;
        sb.push_back(8'h66);
        push_key(8'h5A);
        push_cipher(8'h04, 8'h3C);
        check("lat_push_edge_valid", 32'(bus.plain_valid), 32'h0);
        tick();
        check("lat_pop_edge_valid", 32'(bus.plain_valid), 32'h1);
        check("lat_pop_edge_data", 32'(bus.plain_data), 32'h66);
        tick();
        check("basic_valid_one_cycle", 32'(bus.plain_valid), 32'h0);
        check("basic_count", 32'(bus.byte_count), 32'd1);

        // Port decode: a write to another port must not enter the cipher FIFO.
        do_reset();
        bus.plain_ready = 1'b1;
        push_key(8'h11);
        push_cipher(8'h05, 8'h22);
        repeat (3) tick();
        check("decode_no_valid", 32'(bus.plain_valid), 32'h0);
        sb.push_back(8'h22);
        push_cipher(8'h04, 8'h33);
        wait_drain("decode_drain", 20);
        check("decode_data", 32'(bus.plain_data), 32'h22);
        check("decode_count", 32'(bus.byte_count), 32'd1);

        // Vector table.
        do_reset();
        bus.plain_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(vecs[i].plain);
            push_key(vecs[i].key);
            push_cipher(8'h04, vecs[i].cipher);
            wait_drain("table_drain", 20);
            check("table_data", 32'(bus.plain_data), 32'(vecs[i].plain));
            check("table_count", 32'(bus.byte_count), 32'(i + 1));
        end

        // Skew: ciphers wait for late keys, then drain one per cycle.
        do_reset();
        bus.plain_ready = 1'b1;
        push_cipher(8'h04, 8'h0F);
        push_cipher(8'h04, 8'hA5);
        push_cipher(8'h04, 8'h30);
        repeat (10) tick();
        check("skew_no_key_valid", 32'(bus.plain_valid), 32'h0);
        sb.push_back(8'hF0);
        sb.push_back(8'h5A);
        sb.push_back(8'hCF);
        push_key(8'hFF);
        push_key(8'hFF);
        pat[3] = bus.plain_valid;
        push_key(8'hFF);
        pat[2] = bus.plain_valid;
        tick();
        pat[1] = bus.plain_valid;
        tick();
        pat[0] = bus.plain_valid;
        check("skew_valid_pattern", 32'(pat), 32'b1110);
        wait_drain("skew_drain", 20);
        check("skew_count", 32'(bus.byte_count), 32'd3);

        // Backpressure: output register plus DEPTH entries, sixth pair drops.
        do_reset();
        bus.plain_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(8'(i) ^ (8'hA0 + 8'(i)));
            push_pair(8'hA0 + 8'(i), 8'(i));
            if (i == 4) check("ovf_after_5th", 32'(bus.overflow), 32'h0);
            if (i == 5) check("ovf_after_6th", 32'(bus.overflow), 32'h1);
        end
        tick();
        check("bp_hold_valid", 32'(bus.plain_valid), 32'h1);
        check("bp_hold_data", 32'(bus.plain_data), 32'hA0);
        bus.plain_ready = 1'b1;
        wait_drain("bp_drain", 30);
        check("bp_count", 32'(bus.byte_count), 32'd5);
        check("bp_ovf_sticky", 32'(bus.overflow), 32'h1);

        // Reset mid-stream with one byte presented and two buffered.
        bus.plain_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(8'h0F, 8'h10 + 8'(i));
        tick();
        check("mid_valid_before", 32'(bus.plain_valid), 32'h1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sb.delete();
        check("mid_rst_valid", 32'(bus.plain_valid), 32'h0);
        check("mid_rst_data", 32'(bus.plain_data), 32'h00);
        check("mid_rst_count", 32'(bus.byte_count), 32'h0);
        check("mid_rst_overflow", 32'(bus.overflow), 32'h0);
        bus.plain_ready = 1'b1;
        repeat (4) tick();
        check("mid_rst_discarded", 32'(bus.plain_valid), 32'h0);
        sb.push_back(8'h66);
        push_key(8'h5A);
        push_cipher(8'h04, 8'h3C);
        wait_drain("cold_drain", 20);
        check("cold_data", 32'(bus.plain_data), 32'h66);
        check("cold_count", 32'(bus.byte_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
